decode_stage: RTL and testbench
===============================

# decode_stage

Pipelined, parametrised RV32I instruction decode stage between fetch and register read/issue. It accepts one instruction word plus PC per handshake and decodes every RV32I base format (R, I-load, I-ALU, JALR, S, B, U, J, SYSTEM/FENCE). It produces a command code, register indices, an XLEN-wide sign-extended immediate, a field-valid mask and an illegal-instruction flag. A two-entry skid buffer gives full-throughput valid/ready flow with a registered `in_ready`.

## Interface
- XLEN, 32, width of immediate and PC datapath (32 or 64)
- CMD_W, 7, width of command code; codes are the shared `cmd_*` macros
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline kill (branch mispredict/trap)
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage can accept; registered
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_cmd  out  CMD_W  command code
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate
- out_pc  out  XLEN  PC of decoded instruction
- out_valid_field  out  4  {rd, rs1, rs2, imm} used mask
- out_illegal  out  1  undecodable instruction

## Operation
- Storage: output register (OUT) and skid register (SKID), each with a valid bit. Decode is combinational on `in_inst` and is captured into OUT or SKID.
- Accept when `in_valid && in_ready`. If OUT is empty or draining (`out_ready`), the decoded word goes to OUT. Otherwise it goes to SKID.
- On an OUT drain with SKID full, SKID moves to OUT.
- `in_ready` is the registered value `!SKID.valid`.
- Masks:
  - R: 1110
  - load, I-ALU, JALR: 1101
  - S, B: 0111
  - LUI, AUIPC, JAL: 1001
  - FENCE, ECALL, EBREAK: 0000
- Immediates sign-extended from inst[31]:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Fields not covered by the mask are driven 0; the outputs never carry X.
- SLLI/SRLI/SRAI: imm[4:0] = shamt. Nonzero inst[31:25] other than 0100000 (SRAI) is illegal.
- Illegal conditions: unknown opcode, unknown funct3/funct7, or inst[1:0] != 11. Response: `out_illegal`=1, `out_cmd`=0, mask 0000, `out_pc` retained.

## Timing
- Latency: 1 cycle, accept edge to `out_valid`. Throughput: 1/cycle while `out_ready`=1.
- Reset values:
  - `out_valid`=0, `out_illegal`=0, all data outputs 0
  - SKID empty, so `in_ready`=1 from the first edge after release
- Reset asserted mid-stream drops OUT and SKID contents immediately.
- `flush` has top priority. At the edge it clears OUT.valid and SKID.valid and discards any same-cycle accept. `in_ready` is 1 the following cycle.
- Stall: while `out_valid && !out_ready`, the OUT contents are held stable.
- Back-pressure with SKID full: `in_ready`=0 on the next cycle.
- Simultaneous drain and accept with SKID full: SKID moves to OUT, the new word goes to SKID, and `in_ready` stays 0.

## Configuration
- DECODE_RV32M_EN defined: opcode 0110011 with funct7 0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU to `cmd_mul`..`cmd_remu`, mask 1110.
- DECODE_RV32M_EN undefined: those encodings are flagged illegal.

## Test plan
- Reset, then ADDI x5,x1,-1 (0xFFF08293): next cycle `out_valid`=1, `cmd_addi`, rd=5, rs1=1, imm=all ones, mask 1101.
- BEQ x1,x2,-4 (0xFE208EE3) and JAL x1,+2048 (0x001000EF): imm=0x…FFFC (mask 0111) and imm=0x800 (mask 1001).
- Hold `out_ready`=0 and feed three instructions: first held in OUT, second in SKID, `in_ready`=0. Release: all three emerge in order with no loss or duplication.
- `flush` pulsed with OUT and SKID full plus a concurrent `in_valid`: next cycle `out_valid`=0 and `in_ready`=1, and nothing from the flushed words appears.
- 0x02208033 (MUL): with DECODE_RV32M_EN, `cmd_mul` and mask 1110. Without it, `out_illegal`=1 and mask 0000. Also 0x00000000: `out_illegal`=1.
- Assert `rst` while streaming: outputs go 0 asynchronously, and after release `in_ready`=1 and `out_valid`=0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage
//   Pipelined RV32I instruction decode stage sitting between fetch and
//   register read / issue. One instruction word plus its PC is accepted per
//   valid/ready handshake, decoded combinationally, and captured into an
//   output register backed by a single skid register so that full
//   throughput is kept with a registered in_ready.
//
// Optional feature macro: DECODE_RV32M_EN
//   Defined   -> the RV32M multiply/divide encodings decode to CMD_MUL..CMD_REMU.
//   Undefined -> those encodings are reported as illegal.
//
// Parameters
//   XLEN   width of the immediate and PC datapath (32 or 64)
//   CMD_W  width of the command code (codes are the shared CMD_* macros)
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous, active-low reset
//   flush            synchronous pipeline kill, highest priority
//   in_valid/ready   fetch-side handshake (in_ready is a flop)
//   in_inst, in_pc   instruction word and its address
//   out_valid/ready  issue-side handshake
//   out_cmd          command code, 0 for an illegal instruction
//   out_rd/rs1/rs2   register indices, 0 when not used by the format
//   out_imm          sign-extended immediate, 0 when not used
//   out_pc           PC of the decoded instruction (kept for illegal ones)
//   out_valid_field  {rd, rs1, rs2, imm} used mask
//   out_illegal      undecodable instruction

`ifndef DECODE_STAGE_CMD_CODES
`define DECODE_STAGE_CMD_CODES
`define CMD_NONE   7'd0
`define CMD_LUI    7'd1
`define CMD_AUIPC  7'd2
`define CMD_JAL    7'd3
`define CMD_JALR   7'd4
`define CMD_BEQ    7'd5
`define CMD_BNE    7'd6
`define CMD_BLT    7'd7
`define CMD_BGE    7'd8
`define CMD_BLTU   7'd9
`define CMD_BGEU   7'd10
`define CMD_LB     7'd11
`define CMD_LH     7'd12
`define CMD_LW     7'd13
`define CMD_LBU    7'd14
`define CMD_LHU    7'd15
`define CMD_SB     7'd16
`define CMD_SH     7'd17
`define CMD_SW     7'd18
`define CMD_ADDI   7'd19
`define CMD_SLTI   7'd20
`define CMD_SLTIU  7'd21
`define CMD_XORI   7'd22
`define CMD_ORI    7'd23
`define CMD_ANDI   7'd24
`define CMD_SLLI   7'd25
`define CMD_SRLI   7'd26
`define CMD_SRAI   7'd27
`define CMD_ADD    7'd28
`define CMD_SUB    7'd29
`define CMD_SLL    7'd30
`define CMD_SLT    7'd31
`define CMD_SLTU   7'd32
`define CMD_XOR    7'd33
`define CMD_SRL    7'd34
`define CMD_SRA    7'd35
`define CMD_OR     7'd36
`define CMD_AND    7'd37
`define CMD_FENCE  7'd38
`define CMD_ECALL  7'd39
`define CMD_EBREAK 7'd40
`define CMD_MUL    7'd41
`define CMD_MULH   7'd42
`define CMD_MULHSU 7'd43
`define CMD_MULHU  7'd44
`define CMD_DIV    7'd45
`define CMD_DIVU   7'd46
`define CMD_REM    7'd47
`define CMD_REMU   7'd48
`endif

module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CMD_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CMD_W-1:0] out_cmd,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_valid_field,
  output logic             out_illegal
);

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [3:0]       vf;
    logic             illegal;
  } bundle_t;

  bundle_t     dec;
  bundle_t     out_q;
  bundle_t     skid_q;
  logic        out_v;
  logic        skid_v;
  logic        ready_q;
  logic        accept;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [6:0]  cmd_n;
  logic [3:0]  fmt;
  logic [31:0] imm32;

  assign accept = in_valid && ready_q;

  // Combinational decode of the incoming word. Each opcode picks a command
  // code, a {rd,rs1,rs2,imm} mask and a 32-bit immediate; a command code of
  // CMD_NONE at the end means nothing matched, which is what marks the word
  // illegal. Unused fields are forced to zero so the bundle never carries
  // stale instruction bits.
  always_comb begin
    opcode = in_inst[6:0];
    f3     = in_inst[14:12];
    f7     = in_inst[31:25];
    cmd_n  = `CMD_NONE;
    fmt    = 4'b0000;
    imm32  = '0;
    dec    = '0;

    if (in_inst[1:0] == 2'b11) begin
      case (opcode)
        7'b0110111: begin
          cmd_n = `CMD_LUI;
          fmt   = 4'b1001;
          imm32 = {in_inst[31:12], 12'b0};
        end
        7'b0010111: begin
          cmd_n = `CMD_AUIPC;
          fmt   = 4'b1001;
          imm32 = {in_inst[31:12], 12'b0};
        end
        7'b1101111: begin
          cmd_n = `CMD_JAL;
          fmt   = 4'b1001;
          imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        end
        7'b1100111: begin
          if (f3 == 3'b000) cmd_n = `CMD_JALR;
          fmt   = 4'b1101;
          imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        end
        7'b1100011: begin
          case (f3)
            3'b000:  cmd_n = `CMD_BEQ;
            3'b001:  cmd_n = `CMD_BNE;
            3'b100:  cmd_n = `CMD_BLT;
            3'b101:  cmd_n = `CMD_BGE;
            3'b110:  cmd_n = `CMD_BLTU;
            3'b111:  cmd_n = `CMD_BGEU;
            default: cmd_n = `CMD_NONE;
          endcase
          fmt   = 4'b0111;
          imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        end
        7'b0000011: begin
          case (f3)
            3'b000:  cmd_n = `CMD_LB;
            3'b001:  cmd_n = `CMD_LH;
            3'b010:  cmd_n = `CMD_LW;
            3'b100:  cmd_n = `CMD_LBU;
            3'b101:  cmd_n = `CMD_LHU;
            default: cmd_n = `CMD_NONE;
          endcase
          fmt   = 4'b1101;
          imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        end
        7'b0100011: begin
          case (f3)
            3'b000:  cmd_n = `CMD_SB;
            3'b001:  cmd_n = `CMD_SH;
            3'b010:  cmd_n = `CMD_SW;
            default: cmd_n = `CMD_NONE;
          endcase
          fmt   = 4'b0111;
          imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        end
        7'b0010011: begin
          fmt   = 4'b1101;
          imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
          case (f3)
            3'b000: cmd_n = `CMD_ADDI;
            3'b010: cmd_n = `CMD_SLTI;
            3'b011: cmd_n = `CMD_SLTIU;
            3'b100: cmd_n = `CMD_XORI;
            3'b110: cmd_n = `CMD_ORI;
            3'b111: cmd_n = `CMD_ANDI;
            // Shifts carry only the shamt as immediate; the upper bits
            // select arithmetic vs logical and anything else is rejected.
            3'b001: begin
              imm32 = {27'b0, in_inst[24:20]};
              if (f7 == 7'b0000000) cmd_n = `CMD_SLLI;
            end
            default: begin
              imm32 = {27'b0, in_inst[24:20]};
              if (f7 == 7'b0000000)      cmd_n = `CMD_SRLI;
              else if (f7 == 7'b0100000) cmd_n = `CMD_SRAI;
            end
          endcase
        end
        7'b0110011: begin
          fmt = 4'b1110;
          if (f7 == 7'b0000000) begin
            case (f3)
              3'b000:  cmd_n = `CMD_ADD;
              3'b001:  cmd_n = `CMD_SLL;
              3'b010:  cmd_n = `CMD_SLT;
              3'b011:  cmd_n = `CMD_SLTU;
              3'b100:  cmd_n = `CMD_XOR;
              3'b101:  cmd_n = `CMD_SRL;
              3'b110:  cmd_n = `CMD_OR;
              default: cmd_n = `CMD_AND;
            endcase
          end else if (f7 == 7'b0100000) begin
            if (f3 == 3'b000)      cmd_n = `CMD_SUB;
            else if (f3 == 3'b101) cmd_n = `CMD_SRA;
          end
`ifdef DECODE_RV32M_EN
          else if (f7 == 7'b0000001) begin
            case (f3)
              3'b000:  cmd_n = `CMD_MUL;
              3'b001:  cmd_n = `CMD_MULH;
              3'b010:  cmd_n = `CMD_MULHSU;
              3'b011:  cmd_n = `CMD_MULHU;
              3'b100:  cmd_n = `CMD_DIV;
              3'b101:  cmd_n = `CMD_DIVU;
              3'b110:  cmd_n = `CMD_REM;
              default: cmd_n = `CMD_REMU;
            endcase
          end
`endif
        end
        7'b0001111: begin
          if (f3 == 3'b000) cmd_n = `CMD_FENCE;
        end
        7'b1110011: begin
          // Only the two fully-zero-field SYSTEM encodings are base RV32I.
          if (in_inst[31:7] == 25'd0)          cmd_n = `CMD_ECALL;
          else if (in_inst[31:7] == 25'h2000)  cmd_n = `CMD_EBREAK;
        end
        default: cmd_n = `CMD_NONE;
      endcase
    end

    if (cmd_n == `CMD_NONE) fmt = 4'b0000;

    dec.cmd     = CMD_W'(cmd_n);
    dec.illegal = (cmd_n == `CMD_NONE);
    dec.vf      = fmt;
    dec.rd      = fmt[3] ? in_inst[11:7]  : 5'd0;
    dec.rs1     = fmt[2] ? in_inst[19:15] : 5'd0;
    dec.rs2     = fmt[1] ? in_inst[24:20] : 5'd0;
    dec.imm     = fmt[0] ? XLEN'($signed(imm32)) : '0;
    dec.pc      = in_pc;
  end

  // OUT/SKID pipeline. OUT may be loaded whenever it is empty or being
  // drained; the skid entry always has priority into OUT so ordering is
  // kept. A word arriving while OUT is stalled parks in SKID. in_ready is
  // registered as "SKID will be empty after this edge"; flush drops both
  // entries and any same-cycle accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      skid_q  <= '0;
      out_v   <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b0;
    end else if (flush) begin
      out_v   <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
    end else if (!out_v || out_ready) begin
      if (skid_v) begin
        out_q   <= skid_q;
        out_v   <= 1'b1;
        if (accept) skid_q <= dec;
        skid_v  <= accept;
        ready_q <= !accept;
      end else begin
        if (accept) out_q <= dec;
        out_v   <= accept;
        ready_q <= 1'b1;
      end
    end else if (accept) begin
      skid_q  <= dec;
      skid_v  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      ready_q <= !skid_v;
    end
  end

  assign in_ready        = ready_q;
  assign out_valid       = out_v;
  assign out_cmd         = out_q.cmd;
  assign out_rd          = out_q.rd;
  assign out_rs1         = out_q.rs1;
  assign out_rs2         = out_q.rs2;
  assign out_imm         = out_q.imm;
  assign out_pc          = out_q.pc;
  assign out_valid_field = out_q.vf;
  assign out_illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Scoreboard bench for decode_stage. A table of hand-decoded instructions
//   is fed through the fetch handshake; every accepted word pushes its
//   expected bundle, and every output transfer pops and compares it.
//   Covers reset, streaming decode, stall with skid, flush and mid-stream
//   reset. Honours DECODE_RV32M_EN for the MUL expectation.

module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int CMD_W = 7;

  localparam logic [6:0] C_LUI = 7'd1, C_AUIPC = 7'd2, C_JAL = 7'd3, C_JALR = 7'd4;
  localparam logic [6:0] C_BEQ = 7'd5, C_LW = 7'd13, C_SW = 7'd18, C_ADDI = 7'd19;
  localparam logic [6:0] C_SRAI = 7'd27, C_ADD = 7'd28, C_SUB = 7'd29;
  localparam logic [6:0] C_FENCE = 7'd38, C_ECALL = 7'd39, C_MUL = 7'd41;

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  cmd;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  vf;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [CMD_W-1:0] out_cmd;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [XLEN-1:0]  out_imm;
  logic [XLEN-1:0]  out_pc;
  logic [3:0]       out_valid_field;
  logic             out_illegal;

  vec_t        tbl[$];
  exp_t        expq[$];
  exp_t        monE;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] nextPc = 32'h0000_1000;
  logic [31:0] pcA;

  decode_stage #(.XLEN(XLEN), .CMD_W(CMD_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_pc(out_pc),
    .out_valid_field(out_valid_field), .out_illegal(out_illegal)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Offer table entry idx until it is accepted (bounded), pushing the
  // expected bundle at the cycle the handshake completes.
  task automatic applyStimulus(input int idx);
    bit   accepted;
    exp_t e;
    in_inst  = tbl[idx].inst;
    in_pc    = nextPc;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready && !flush && rst) begin
        e.v = tbl[idx];
        e.pc = nextPc;
        expq.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) checkOutput("accept_timeout", 64'(accepted), 64'(1));
    nextPc   = nextPc + 32'd4;
    in_valid = 1'b0;
  endtask

  // Hand-decoded reference vectors.
  task automatic buildTable();
    tbl.push_back('{32'hFFF08293, C_ADDI,  5'd5,  5'd1,  5'd0, 32'hFFFF_FFFF, 4'b1101, 1'b0}); // 0 ADDI x5,x1,-1
    tbl.push_back('{32'hFE208EE3, C_BEQ,   5'd0,  5'd1,  5'd2, 32'hFFFF_FFFC, 4'b0111, 1'b0}); // 1 BEQ x1,x2,-4
    tbl.push_back('{32'h001000EF, C_JAL,   5'd1,  5'd0,  5'd0, 32'h0000_0800, 4'b1001, 1'b0}); // 2 JAL x1,+2048
`ifdef DECODE_RV32M_EN
    tbl.push_back('{32'h02208033, C_MUL,   5'd0,  5'd1,  5'd2, 32'h0,         4'b1110, 1'b0}); // 3 MUL
`else
    tbl.push_back('{32'h02208033, 7'd0,    5'd0,  5'd0,  5'd0, 32'h0,         4'b0000, 1'b1}); // 3 MUL -> illegal
`endif
    tbl.push_back('{32'h00000000, 7'd0,    5'd0,  5'd0,  5'd0, 32'h0,         4'b0000, 1'b1}); // 4 all zero
    tbl.push_back('{32'h005201B3, C_ADD,   5'd3,  5'd4,  5'd5, 32'h0,         4'b1110, 1'b0}); // 5 ADD x3,x4,x5
    tbl.push_back('{32'h405201B3, C_SUB,   5'd3,  5'd4,  5'd5, 32'h0,         4'b1110, 1'b0}); // 6 SUB x3,x4,x5
    tbl.push_back('{32'hABCDE3B7, C_LUI,   5'd7,  5'd0,  5'd0, 32'hABCD_E000, 4'b1001, 1'b0}); // 7 LUI x7
    tbl.push_back('{32'hFE612C23, C_SW,    5'd0,  5'd2,  5'd6, 32'hFFFF_FFF8, 4'b0111, 1'b0}); // 8 SW x6,-8(x2)
    tbl.push_back('{32'h40315093, C_SRAI,  5'd1,  5'd2,  5'd0, 32'h0000_0003, 4'b1101, 1'b0}); // 9 SRAI x1,x2,3
    tbl.push_back('{32'h40311093, 7'd0,    5'd0,  5'd0,  5'd0, 32'h0,         4'b0000, 1'b1}); // 10 SLLI bad funct7
    tbl.push_back('{32'h00000073, C_ECALL, 5'd0,  5'd0,  5'd0, 32'h0,         4'b0000, 1'b0}); // 11 ECALL
    tbl.push_back('{32'h0105A503, C_LW,    5'd10, 5'd11, 5'd0, 32'h0000_0010, 4'b1101, 1'b0}); // 12 LW x10,16(x11)
    tbl.push_back('{32'hFFF08290, 7'd0,    5'd0,  5'd0,  5'd0, 32'h0,         4'b0000, 1'b1}); // 13 low bits != 11
    tbl.push_back('{32'h004280E7, C_JALR,  5'd1,  5'd5,  5'd0, 32'h0000_0004, 4'b1101, 1'b0}); // 14 JALR x1,4(x5)
    tbl.push_back('{32'h80000117, C_AUIPC, 5'd2,  5'd0,  5'd0, 32'h8000_0000, 4'b1001, 1'b0}); // 15 AUIPC x2
    tbl.push_back('{32'h0FF0000F, C_FENCE, 5'd0,  5'd0,  5'd0, 32'h0,         4'b0000, 1'b0}); // 16 FENCE
  endtask

  // Output monitor: a transfer is visible at the negedge before the edge
  // that completes it. Flush empties the scoreboard; reset suspends it.
  always @(negedge clk) begin
    if (rst && flush) begin
      expq.delete();
    end else if (rst && out_valid && out_ready) begin
      checkOutput("sb_nonempty", 64'(expq.size() > 0), 64'(1));
      if (expq.size() > 0) begin
        monE = expq.pop_front();
        checkOutput($sformatf("cmd@%h", monE.v.inst),     64'(out_cmd),         64'(monE.v.cmd));
        checkOutput($sformatf("rd@%h", monE.v.inst),      64'(out_rd),          64'(monE.v.rd));
        checkOutput($sformatf("rs1@%h", monE.v.inst),     64'(out_rs1),         64'(monE.v.rs1));
        checkOutput($sformatf("rs2@%h", monE.v.inst),     64'(out_rs2),         64'(monE.v.rs2));
        checkOutput($sformatf("imm@%h", monE.v.inst),     64'(out_imm),         64'(monE.v.imm));
        checkOutput($sformatf("mask@%h", monE.v.inst),    64'(out_valid_field), 64'(monE.v.vf));
        checkOutput($sformatf("illegal@%h", monE.v.inst), 64'(out_illegal),     64'(monE.v.ill));
        checkOutput($sformatf("pc@%h", monE.v.inst),      64'(out_pc),          64'(monE.pc));
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    buildTable();

    // Reset state
    #12;
    checkOutput("rst_out_valid", 64'(out_valid),       64'(0));
    checkOutput("rst_illegal",   64'(out_illegal),     64'(0));
    checkOutput("rst_cmd",       64'(out_cmd),         64'(0));
    checkOutput("rst_imm",       64'(out_imm),         64'(0));
    checkOutput("rst_pc",        64'(out_pc),          64'(0));
    checkOutput("rst_mask",      64'(out_valid_field), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready",  64'(in_ready),  64'(1));
    checkOutput("post_rst_out_valid", 64'(out_valid), 64'(0));

    // Streaming decode, back to back
    applyStimulus(0);
    checkOutput("latency_valid", 64'(out_valid), 64'(1));
    for (int i = 1; i < tbl.size(); i++) applyStimulus(i);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stream_drained", 64'(expq.size()), 64'(0));

    // Stall: first in OUT, second in SKID, third waits for release
    out_ready = 1'b0;
    pcA = nextPc;
    applyStimulus(5);
    applyStimulus(7);
    checkOutput("skid_full_ready", 64'(in_ready),  64'(0));
    checkOutput("stall_valid",     64'(out_valid), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_hold_pc",  64'(out_pc),    64'(pcA));
    checkOutput("stall_hold_cmd", 64'(out_cmd),   64'(C_ADD));
    checkOutput("stall_ready",    64'(in_ready),  64'(0));
    fork
      applyStimulus(9);
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stall_drained", 64'(expq.size()), 64'(0));

    // Flush with OUT and SKID full plus a concurrent offer
    out_ready = 1'b0;
    applyStimulus(1);
    applyStimulus(2);
    in_inst  = tbl[6].inst;
    in_pc    = nextPc;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_out_valid", 64'(out_valid), 64'(0));
    checkOutput("flush_in_ready",  64'(in_ready),  64'(1));
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("flush_quiet", 64'(out_valid), 64'(0));
    applyStimulus(12);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("post_flush_drained", 64'(expq.size()), 64'(0));

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    applyStimulus(15);
    applyStimulus(14);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(out_valid),       64'(0));
    checkOutput("async_rst_cmd",   64'(out_cmd),         64'(0));
    checkOutput("async_rst_imm",   64'(out_imm),         64'(0));
    checkOutput("async_rst_pc",    64'(out_pc),          64'(0));
    checkOutput("async_rst_mask",  64'(out_valid_field), 64'(0));
    expq.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rerst_in_ready",  64'(in_ready),  64'(1));
    checkOutput("rerst_out_valid", 64'(out_valid), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rerst_quiet", 64'(out_valid), 64'(0));

    checkOutput("sb_empty", 64'(expq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
